// File: rtl/ahblite_iic_target.sv
// AHB-lite I2C target: a small 8-bit register bank shared between an
// external I2C controller and the CPU, plus STATUS/CTRL and a write-done IRQ.
// SCL/SDA are oversampled on HCLK; SDA is open-drain (drives 0 or Z).
module ahblite_iic_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h2C,
  parameter int unsigned PTR_W    = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  input  logic        IIC_SCL,
  inout  wire         IIC_SDA,
  output logic        IRQ
);

  localparam int unsigned NREG = 1 << PTR_W;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } iicState_e;

  // Synchronizer and edge-detect stages (bus idles high)
  logic sclS1_q, sclS2_q, sclS3_q;
  logic sdaS1_q, sdaS2_q, sdaS3_q;

  // I2C protocol state
  iicState_e        state_q, state_d;
  logic [3:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       tx_q, tx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rw_q, rw_d;
  logic             sdaOe_q, sdaOe_d;
  logic             wrSeen_q, wrSeen_d;

  // Register bank, status and control
  logic [7:0] regs_q [NREG];
  logic [7:0] regs_d [NREG];
  logic       wdone_q, wdone_d;
  logic       nacked_q, nacked_d;
  logic       ie_q, ie_d;

  // AHB data-phase bookkeeping
  logic       ahbWr_q, ahbRd_q;
  logic [2:0] ahbAddr_q;

  logic             sclRise, sclFall, startDet, stopDet, sdaIn;
  logic             i2cWrEn, setWdone, setNacked, busy, regHit;
  logic [PTR_W-1:0] ahbIdx;
  logic [7:0]       rdByte;
  logic             unusedInputs;

  assign sclRise  = sclS2_q & ~sclS3_q;
  assign sclFall  = ~sclS2_q & sclS3_q;
  assign sdaIn    = sdaS2_q;
  assign startDet = sclS2_q & sclS3_q & ~sdaS2_q & sdaS3_q;
  assign stopDet  = sclS2_q & sclS3_q & sdaS2_q & ~sdaS3_q;

  assign busy   = (state_q != ST_IDLE);
  assign ahbIdx = ahbAddr_q[PTR_W-1:0];
  assign regHit = (ahbAddr_q < 3'(NREG));

  assign IIC_SDA   = sdaOe_q ? 1'b0 : 1'bz;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign HRDATA    = {24'h0, rdByte};
  assign IRQ       = wdone_q & ie_q;

  assign unusedInputs = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HSIZE, HPROT, HWDATA[31:8]};

  // Two-stage synchronizers on SCL/SDA plus a third stage for edge detection
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      {sclS1_q, sclS2_q, sclS3_q} <= 3'b111;
      {sdaS1_q, sdaS2_q, sdaS3_q} <= 3'b111;
    end else begin
      {sclS1_q, sclS2_q, sclS3_q} <= {IIC_SCL, sclS1_q, sclS2_q};
      {sdaS1_q, sdaS2_q, sdaS3_q} <= {IIC_SDA, sdaS1_q, sdaS2_q};
    end
  end

  // Latch the AHB address phase so the write/read happens in the data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ahbWr_q   <= 1'b0;
      ahbRd_q   <= 1'b0;
      ahbAddr_q <= 3'd0;
    end else if (HREADY) begin
      ahbWr_q   <= HSEL & HTRANS[1] & HWRITE;
      ahbRd_q   <= HSEL & HTRANS[1] & ~HWRITE;
      ahbAddr_q <= HADDR[4:2];
    end
  end

  // I2C state register and datapath registers; reset releases SDA at once
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      bitCnt_q <= 4'd0;
      shift_q  <= 8'h00;
      tx_q     <= 8'h00;
      ptr_q    <= '0;
      rw_q     <= 1'b0;
      sdaOe_q  <= 1'b0;
      wrSeen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ptr_q    <= ptr_d;
      rw_q     <= rw_d;
      sdaOe_q  <= sdaOe_d;
      wrSeen_q <= wrSeen_d;
    end
  end

  // I2C next-state logic: sample on SCL rise, change SDA drive on SCL fall
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sdaOe_d   = sdaOe_q;
    wrSeen_d  = wrSeen_q;
    i2cWrEn   = 1'b0;
    setWdone  = 1'b0;
    setNacked = 1'b0;

    if (startDet) begin
      state_d  = ST_ADDR;
      bitCnt_d = 4'd0;
      sdaOe_d  = 1'b0;
    end else if (stopDet) begin
      state_d  = ST_IDLE;
      bitCnt_d = 4'd0;
      sdaOe_d  = 1'b0;
      setWdone = wrSeen_q;
      wrSeen_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (sclRise && bitCnt_q != 4'd8) begin
            shift_d  = {shift_q[6:0], sdaIn};
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall && bitCnt_q == 4'd8) begin
            bitCnt_d = 4'd0;
            case (state_q)
              ST_ADDR: begin
                if (shift_q[7:1] == DEV_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  sdaOe_d = 1'b1;
                  rw_d    = shift_q[0];
                end else begin
                  state_d = ST_IGNORE;
                end
              end
              ST_PTR: begin
                ptr_d   = shift_q[PTR_W-1:0];
                state_d = ST_PTR_ACK;
                sdaOe_d = 1'b1;
              end
              default: begin
                i2cWrEn  = 1'b1;
                ptr_d    = ptr_q + 1'b1;
                wrSeen_d = 1'b1;
                state_d  = ST_WDATA_ACK;
                sdaOe_d  = 1'b1;
              end
            endcase
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (sclFall) begin
            if (state_q == ST_ADDR_ACK && rw_q) begin
              state_d = ST_RDATA;
              tx_d    = regs_q[ptr_q];
              sdaOe_d = ~regs_q[ptr_q][7];
            end else begin
              state_d = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
              sdaOe_d = 1'b0;
            end
          end
        end
        ST_RDATA: begin
          if (sclRise && bitCnt_q != 4'd8) begin
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall && bitCnt_q == 4'd8) begin
            state_d  = ST_RACK;
            bitCnt_d = 4'd0;
            sdaOe_d  = 1'b0;
            ptr_d    = ptr_q + 1'b1;
          end else if (sclFall && bitCnt_q != 4'd0) begin
            tx_d    = {tx_q[6:0], 1'b0};
            sdaOe_d = ~tx_q[6];
          end
        end
        ST_RACK: begin
          if (sclRise && bitCnt_q == 4'd0) begin
            if (sdaIn) begin
              setNacked = 1'b1;
              state_d   = ST_IGNORE;
            end else begin
              bitCnt_d = 4'd1;
            end
          end else if (sclFall && bitCnt_q == 4'd1) begin
            state_d  = ST_RDATA;
            bitCnt_d = 4'd0;
            tx_d     = regs_q[ptr_q];
            sdaOe_d  = ~regs_q[ptr_q][7];
          end
        end
        default: begin
          sdaOe_d = 1'b0;
        end
      endcase
    end
  end

  // Register bank, STATUS and CTRL next values; I2C writes and status sets win collisions
  always_comb begin
    regs_d   = regs_q;
    wdone_d  = wdone_q;
    nacked_d = nacked_q;
    ie_d     = ie_q;
    if (ahbWr_q) begin
      if (regHit) begin
        regs_d[ahbIdx] = HWDATA[7:0];
      end else if (ahbAddr_q == 3'd4) begin
        if (HWDATA[0]) wdone_d  = 1'b0;
        if (HWDATA[2]) nacked_d = 1'b0;
      end else if (ahbAddr_q == 3'd5) begin
        ie_d = HWDATA[0];
      end
    end
    if (i2cWrEn) regs_d[ptr_q] = shift_q;
    if (setWdone) wdone_d = 1'b1;
    if (setNacked) nacked_d = 1'b1;
  end

  // Register bank, STATUS and CTRL storage
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
      wdone_q  <= 1'b0;
      nacked_q <= 1'b0;
      ie_q     <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      wdone_q  <= wdone_d;
      nacked_q <= nacked_d;
      ie_q     <= ie_d;
    end
  end

  // AHB read mux for the latched data-phase address; unmapped offsets read 0
  always_comb begin
    rdByte = 8'h00;
    if (ahbRd_q) begin
      if (regHit) begin
        rdByte = regs_q[ahbIdx];
      end else if (ahbAddr_q == 3'd4) begin
        rdByte = {5'b0, nacked_q, busy, wdone_q};
      end else if (ahbAddr_q == 3'd5) begin
        rdByte = {7'b0, ie_q};
      end
    end
  end

endmodule
